// File: rtl/fetch_sequencer.sv
// Fetch controller: sequences the PC through BOOT/FETCH/DELIVER/ERR, issues imem requests and hands instructions to decode.
// Latency: 2 cycles per instruction with imem_ready high; stall holds the delivered instruction, redirects kill in-flight fetches.
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          BOOT_DELAY   = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_next,
   output logic        misaligned_err
);

   localparam int CW = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;

   typedef enum logic [1:0] {BOOT, FETCH, DELIVER, ERR} state_t;

   state_t        state;
   logic [CW-1:0] boot_cnt;
   logic [31:0]   pc;
   logic [31:0]   kill_target;
   logic          kill;
   logic          redirect_bad;

   assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
   assign imem_addr    = imem_req ? pc : 32'h0000_0000;

   // pc_next is exactly the value pc loads at the next edge, so pc simply follows it.
   always_comb begin
      pc_next = pc;
      if (reset) begin
         pc_next = RESET_VECTOR;
      end else begin
         case (state)
            FETCH: begin
               if (redirect_valid) begin
                  if (!redirect_bad && imem_ready) pc_next = redirect_target;
               end else if (imem_ready && kill) begin
                  pc_next = kill_target;
               end
            end
            DELIVER: begin
               if (redirect_valid) begin
                  if (!redirect_bad) pc_next = redirect_target;
               end else if (!stall) begin
                  pc_next = pc + 32'd4;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= BOOT;
         boot_cnt       <= CW'(BOOT_DELAY);
         pc             <= RESET_VECTOR;
         kill           <= 1'b0;
         kill_target    <= 32'h0000_0000;
         instr          <= 32'h0000_0000;
         instr_pc       <= 32'h0000_0000;
         imem_req       <= 1'b0;
         instr_valid    <= 1'b0;
         misaligned_err <= 1'b0;
      end else begin
         pc <= pc_next;
         case (state)
            BOOT: begin
               if (boot_cnt == '0) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
               end else begin
                  boot_cnt <= boot_cnt - CW'(1);
               end
            end
            FETCH: begin
               if (redirect_bad) begin
                  state          <= ERR;
                  imem_req       <= 1'b0;
                  misaligned_err <= 1'b1;
                  kill           <= 1'b0;
               end else if (redirect_valid) begin
                  // Memory not ready: the request must stay up, so remember the target and drop the data later.
                  if (imem_ready) begin
                     kill <= 1'b0;
                  end else begin
                     kill        <= 1'b1;
                     kill_target <= redirect_target;
                  end
               end else if (imem_ready) begin
                  if (kill) begin
                     kill <= 1'b0;
                  end else begin
                     instr       <= imem_rdata;
                     instr_pc    <= pc;
                     state       <= DELIVER;
                     imem_req    <= 1'b0;
                     instr_valid <= 1'b1;
                  end
               end
            end
            DELIVER: begin
               if (redirect_bad) begin
                  state          <= ERR;
                  instr_valid    <= 1'b0;
                  misaligned_err <= 1'b1;
               end else if (redirect_valid || !stall) begin
                  state       <= FETCH;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, all checked against a behavioural model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset, imem_ready, stall, redirect_valid;
   logic [31:0] imem_rdata, redirect_target;
   logic        imem_req, instr_valid, misaligned_err;
   logic [31:0] imem_addr, instr, instr_pc, pc_next;

   int checks   = 0;
   int failures = 0;

   fetch_sequencer #(.RESET_VECTOR(32'h0000_0000), .BOOT_DELAY(4)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .pc_next(pc_next), .misaligned_err(misaligned_err)
   );

   always #5 clk = ~clk;

   // Model: boot countdown (-1 once booted), whether an instruction is being held, dead flag, pending redirect.
   bit          m_known = 1'b0;
   int          m_boot;
   bit          m_hold, m_err, m_kill;
   logic [31:0] m_pc, m_tgt, m_instr, m_ipc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit rst, input bit rdy, input bit stl, input bit rv,
                      input logic [31:0] tgt, input logic [31:0] rd);
      bit          fetching, aligned;
      logic [31:0] exp_next;
      reset = rst; imem_ready = rdy; stall = stl; redirect_valid = rv;
      redirect_target = tgt; imem_rdata = rd;
      #1;
      aligned  = (tgt[1:0] == 2'b00);
      fetching = !m_err && (m_boot < 0) && !m_hold;
      if (m_known) begin
         if (rst)                                exp_next = 32'h0000_0000;
         else if (m_err || m_boot >= 0)          exp_next = m_pc;
         else if (rv)                            exp_next = (aligned && (m_hold || rdy)) ? tgt : m_pc;
         else if (fetching && rdy && m_kill)     exp_next = m_tgt;
         else if (m_hold && !stl)                exp_next = m_pc + 32'd4;
         else                                    exp_next = m_pc;
         check_eq("imem_req",    imem_req,       fetching);
         check_eq("imem_addr",   imem_addr,      fetching ? m_pc : 32'h0);
         check_eq("instr_valid", instr_valid,    m_hold && !m_err);
         check_eq("misaligned",  misaligned_err, m_err);
         check_eq("pc_next",     pc_next,        exp_next);
         check_eq("instr",       instr,          m_instr);
         check_eq("instr_pc",    instr_pc,       m_ipc);
      end
      if (rst) begin
         m_known = 1'b1; m_boot = 4; m_pc = 32'h0; m_kill = 1'b0; m_hold = 1'b0;
         m_err = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
      end else if (m_err) begin
      end else if (m_boot >= 0) begin
         m_boot--;
      end else if (rv) begin
         if (!aligned)    m_err = 1'b1;
         else if (m_hold) begin m_pc = tgt; m_hold = 1'b0; end
         else if (rdy)    begin m_pc = tgt; m_kill = 1'b0; end
         else             begin m_kill = 1'b1; m_tgt = tgt; end
      end else if (fetching && rdy) begin
         if (m_kill) begin m_pc = m_tgt; m_kill = 1'b0; end
         else begin m_instr = rd; m_ipc = m_pc; m_hold = 1'b1; end
      end else if (m_hold && !stl) begin
         m_pc = m_pc + 32'd4; m_hold = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic go(input bit rdy, input bit stl, input bit rv, input logic [31:0] tgt);
      cyc(1'b0, rdy, stl, rv, tgt, m_pc ^ 32'hC0DE_0000);
   endtask

   initial begin
      int n;
      bit seen;
      logic [31:0] r, t;
      reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      redirect_target = 32'h0; imem_rdata = 32'h0;
      @(posedge clk);
      #1;
      cyc(1, 1, 0, 0, 32'h0, 32'h0);
      cyc(1, 1, 0, 0, 32'h0, 32'h0);

      n = 0; seen = 1'b0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         go(1, 0, 0, 32'h0);
         if (imem_req) begin seen = 1'b1; n = i; end
      end
      check_eq("boot_latency", n, 5);
      check_eq("boot_addr", imem_addr, 32'h0);

      repeat (5) go(1, 0, 0, 32'h0);
      repeat (3) go(1, 1, 0, 32'h0);
      check_eq("stall_ipc", instr_pc, 32'h8);
      check_eq("stall_req", imem_req, 1'b0);
      go(1, 0, 0, 32'h0);
      check_eq("after_stall_addr", imem_addr, 32'hC);

      go(0, 0, 1, 32'h80);
      go(0, 0, 1, 32'h100);
      check_eq("kill_addr_held", imem_addr, 32'hC);
      go(0, 0, 0, 32'h0);
      go(1, 0, 0, 32'h0);
      check_eq("redir_addr", imem_addr, 32'h100);
      go(1, 0, 0, 32'h0);
      check_eq("redir_ipc", instr_pc, 32'h100);
      check_eq("redir_instr", instr, 32'h100 ^ 32'hC0DE_0000);

      go(1, 1, 1, 32'hFFFF_FFFC);
      check_eq("redir_stall_valid", instr_valid, 1'b0);
      check_eq("redir_stall_addr", imem_addr, 32'hFFFF_FFFC);
      go(1, 0, 0, 32'h0);
      go(1, 0, 0, 32'h0);
      check_eq("wrap_addr", imem_addr, 32'h0);

      go(1, 0, 0, 32'h0);
      go(1, 1, 1, 32'h102);
      repeat (12) go($urandom % 2, $urandom % 2, $urandom % 2, $urandom);
      check_eq("err_sticky", misaligned_err, 1'b1);
      check_eq("err_noreq", imem_req, 1'b0);
      cyc(1, 1, 0, 0, 32'h0, 32'h0);
      cyc(1, 1, 0, 0, 32'h0, 32'h0);
      check_eq("err_cleared", misaligned_err, 1'b0);
      check_eq("reset_pc_next", pc_next, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         r = $urandom;
         t = ($urandom % 10 == 0) ? r : {r[31:2], 2'b00};
         cyc((i % 400 == 399) || ($urandom % 300 == 0),
             ($urandom % 10) < 7, ($urandom % 10) < 3, ($urandom % 10) == 0, t, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
